// File: rtl/stream_accum_pkg.sv
// Shared types and constants for the frame-accumulating result sink.
package stream_accum_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned SKID_DEPTH = 2;

   // Default frame length and the beat-counter width it implies
   localparam int unsigned FRAME_LEN  = 4;
   localparam int unsigned CNT_WIDTH  = $clog2(FRAME_LEN + 1);

   // Beat-counter width for an arbitrary frame length
   function automatic int unsigned cnt_width(input int unsigned frame_len);
      return $clog2(frame_len + 1);
   endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO with a registered ready; head is visible the cycle after push.
module skid_buf2
   import stream_accum_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  head_valid,
   output logic                  ready
);

   localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      occ_d;
   logic                  ready_q;
   logic                  push_en;
   logic                  pop_en;

   // Qualified push/pop and next occupancy
   always_comb begin
      push_en = push & ready_q;
      pop_en  = pop & head_valid;
      occ_d   = occ_q + OCC_W'(push_en) - OCC_W'(pop_en);
   end

   // Pointers, occupancy and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         occ_q   <= occ_d;
         ready_q <= (occ_d < OCC_W'(SKID_DEPTH));
         if (push_en) wr_ptr_q <= ~wr_ptr_q;
         if (pop_en)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Storage, no reset needed on data
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= din;
   end

   assign dout       = mem_q[rd_ptr_q];
   assign head_valid = (occ_q != '0);
   assign ready      = ready_q;

endmodule

// File: rtl/stream_accum_sink.sv
// Sums every FRAME_LEN result beats into one frame total with a sequence number.
module stream_accum_sink
   import stream_accum_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAME_LEN  = 4,
   parameter int unsigned SUM_WIDTH  = 40,
   parameter int unsigned FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  ready_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [SUM_WIDTH-1:0]  sum_o,
   output logic [FCNT_WIDTH-1:0] fcnt_o
);

   localparam int unsigned       CNT_W    = cnt_width(FRAME_LEN);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

   logic [DATA_WIDTH-1:0] head;
   logic                  head_valid;
   logic [SUM_WIDTH-1:0]  head_ext;
   logic                  pop_c;

   state_t                state_q;
   state_t                state_d;
   logic [SUM_WIDTH-1:0]  acc_q;
   logic [SUM_WIDTH-1:0]  acc_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [SUM_WIDTH-1:0]  sum_d;
   logic                  valid_d;
   logic [FCNT_WIDTH-1:0] fcnt_d;

   skid_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (valid_i),
      .din        (din),
      .pop        (pop_c),
      .dout       (head),
      .head_valid (head_valid),
      .ready      (ready_o)
   );

   assign head_ext = SUM_WIDTH'(head);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACC;
      else        state_q <= state_d;
   end

   // Next state: leave ACC on the last beat, leave HOLD on downstream accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC:     if (head_valid && (cnt_q == LAST_CNT)) state_d = HOLD;
         HOLD:    if (ready_i) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // Pop control and next datapath values; HOLD exit reloads acc from head
   always_comb begin
      pop_c   = 1'b0;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_o;
      valid_d = valid_o;
      fcnt_d  = fcnt_o;
      case (state_q)
         ACC: begin
            if (head_valid) begin
               pop_c = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  sum_d   = acc_q + head_ext;
                  valid_d = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  acc_d = acc_q + head_ext;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (ready_i) begin
               valid_d = 1'b0;
               fcnt_d  = fcnt_o + FCNT_WIDTH'(1);
               if (head_valid) begin
                  pop_c = 1'b1;
                  acc_d = head_ext;
                  cnt_d = CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_o   <= '0;
         valid_o <= 1'b0;
         fcnt_o  <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_o   <= sum_d;
         valid_o <= valid_d;
         fcnt_o  <= fcnt_d;
      end
   end

endmodule
